// File: rtl/tv80_bus_pkg.sv
// tv80_bus_pkg
//   Shared types and constants for the TV80 bus responder.
//   - state_e : responder bus-cycle state (IDLE/WAIT/DATA/HOLD)
//   - kind_e  : decoded machine-cycle kind (M1 fetch, memory, IO)
//   - WAIT_W  : width of the wait-state counter (0..15 waits)
//   - IO_DEFAULT : byte returned on IO reads unless overridden
package tv80_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DATA = 2'd2,
      ST_HOLD = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      CK_M1  = 2'd0,
      CK_MEM = 2'd1,
      CK_IO  = 2'd2
   } kind_e;

   localparam int         WAIT_W     = 4;
   localparam logic [7:0] IO_DEFAULT = 8'hFF;

endpackage

// File: rtl/tb_ram_sp.sv
// tb_ram_sp
//   Single-clock byte RAM, 2**P_ADDR_W deep, with registered read.
//   Ports:
//     i_clk                      : clock
//     i_we / i_waddr / i_wdata   : CPU write port
//     i_raddr / o_rdata          : read port, data registered on i_clk
//     i_ld_we / i_ld_addr / i_ld_data : backdoor write port
//   When both write ports hit the same address in one cycle the CPU
//   write is kept and the backdoor write is discarded.
//   Contents are never reset.
module tb_ram_sp #(
   parameter int P_ADDR_W = 16
) (
   input  logic                i_clk,
   input  logic                i_we,
   input  logic [P_ADDR_W-1:0] i_waddr,
   input  logic [7:0]          i_wdata,
   input  logic [P_ADDR_W-1:0] i_raddr,
   output logic [7:0]          o_rdata,
   input  logic                i_ld_we,
   input  logic [P_ADDR_W-1:0] i_ld_addr,
   input  logic [7:0]          i_ld_data
);

   logic [7:0] mem_q [0:(2**P_ADDR_W)-1];
   logic [7:0] rdata_q;
   logic       ld_ok;

   // Backdoor only loses when the CPU is writing the very same byte.
   assign ld_ok = i_ld_we & ~(i_we & (i_waddr == i_ld_addr));

   always_ff @(posedge i_clk) begin
      if (i_we)
         mem_q[i_waddr] <= i_wdata;
      if (ld_ok)
         mem_q[i_ld_addr] <= i_ld_data;
      rdata_q <= mem_q[i_raddr];
   end

   assign o_rdata = rdata_q;

endmodule

// File: rtl/tv80_mem_responder.sv
// tv80_mem_responder
//   Memory/IO bus responder for the TV80 core in the test harness.
//   Decodes M1 fetch, memory read/write and IO read/write cycles,
//   inserts P_*_WAIT wait states, serves reads from a byte RAM and
//   commits writes. The RAM can be loaded through a backdoor port.
//   Ports:
//     i_clk, i_reset_btn (async, active-high)
//     i_a, i_dout, o_di               : CPU address / write data / read data
//     i_mreq_n .. i_rfsh_n, o_wait_n  : CPU strobes and wait request
//     i_ld_we, i_ld_addr, i_ld_data   : backdoor RAM write
//     o_io_wr, o_io_port, o_io_data   : IO write pulse and last IO write
//     o_wr_count, o_wr_last_addr      : memory write log
//   Build option: MEMRESP_WRLOG_EN enables the write log registers; without
//   it o_wr_count and o_wr_last_addr read as zero.
module tv80_mem_responder
   import tv80_bus_pkg::*;
#(
   parameter int         P_ADDR_W     = 16,
   parameter int         P_M1_WAIT    = 0,
   parameter int         P_MEM_WAIT   = 0,
   parameter int         P_IO_WAIT    = 1,
   parameter logic [7:0] P_IO_DEFAULT = IO_DEFAULT
) (
   input  logic                i_clk,
   input  logic                i_reset_btn,
   input  logic [15:0]         i_a,
   input  logic [7:0]          i_dout,
   output logic [7:0]          o_di,
   input  logic                i_mreq_n,
   input  logic                i_iorq_n,
   input  logic                i_rd_n,
   input  logic                i_wr_n,
   input  logic                i_m1_n,
   input  logic                i_rfsh_n,
   output logic                o_wait_n,
   input  logic                i_ld_we,
   input  logic [P_ADDR_W-1:0] i_ld_addr,
   input  logic [7:0]          i_ld_data,
   output logic                o_io_wr,
   output logic [7:0]          o_io_port,
   output logic [7:0]          o_io_data,
   output logic [15:0]         o_wr_count,
   output logic [15:0]         o_wr_last_addr
);

   localparam logic [WAIT_W-1:0] M1_N  = WAIT_W'(P_M1_WAIT);
   localparam logic [WAIT_W-1:0] MEM_N = WAIT_W'(P_MEM_WAIT);
   localparam logic [WAIT_W-1:0] IO_N  = WAIT_W'(P_IO_WAIT);

   state_e            state_q, state_d;
   kind_e             kind_q, kind_d;
   logic              wr_q, wr_d;
   logic [15:0]       addr_q, addr_d;
   logic [WAIT_W-1:0] cnt_q, cnt_d;
   logic [7:0]        di_q, di_d;
   logic              io_wr_q;
   logic [7:0]        io_port_q, io_port_d;
   logic [7:0]        io_data_q, io_data_d;

   logic              rw_req, mem_start, io_start, bus_active, bus_idle;
   kind_e             start_kind;
   logic [WAIT_W-1:0] start_cnt;
   logic              commit, mem_we, io_we;
   logic [P_ADDR_W-1:0] raddr;
   logic [7:0]        ram_rdata;

   // Refresh (rfsh_n low) and interrupt acknowledge (iorq_n & m1_n low)
   // are excluded from starting a cycle.
   assign rw_req     = ~i_rd_n | ~i_wr_n;
   assign mem_start  = ~i_mreq_n & i_rfsh_n & rw_req;
   assign io_start   = ~i_iorq_n & i_m1_n & rw_req;
   assign bus_active = (~i_mreq_n | ~i_iorq_n) & rw_req;
   assign bus_idle   = i_mreq_n & i_iorq_n & i_rd_n & i_wr_n;

   always_comb begin
      start_kind = CK_IO;
      start_cnt  = IO_N;
      if (mem_start) begin
         start_kind = i_m1_n ? CK_MEM : CK_M1;
         start_cnt  = i_m1_n ? MEM_N : M1_N;
      end
   end

   always_comb begin
      state_d = state_q;
      kind_d  = kind_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (mem_start | io_start) begin
               kind_d  = start_kind;
               wr_d    = ~i_wr_n;
               addr_d  = i_a;
               cnt_d   = start_cnt;
               state_d = (start_cnt != '0) ? ST_WAIT : ST_DATA;
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - 1'b1;
            if (!bus_active)
               state_d = ST_IDLE;
            else if (cnt_q <= 1)
               state_d = ST_DATA;
         end
         ST_DATA: state_d = ST_HOLD;
         ST_HOLD: if (bus_idle) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   assign commit = (state_q == ST_DATA);
   assign mem_we = commit & wr_q & (kind_q != CK_IO);
   assign io_we  = commit & wr_q & (kind_q == CK_IO);

   always_comb begin
      di_d      = di_q;
      io_port_d = io_port_q;
      io_data_d = io_data_q;
      if (commit & ~wr_q)
         di_d = (kind_q == CK_IO) ? P_IO_DEFAULT : ram_rdata;
      if (io_we) begin
         io_port_d = addr_q[7:0];
         io_data_d = i_dout;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset_btn) begin
      if (i_reset_btn) begin
         state_q   <= ST_IDLE;
         kind_q    <= CK_MEM;
         wr_q      <= 1'b0;
         addr_q    <= '0;
         cnt_q     <= '0;
         di_q      <= 8'h00;
         io_wr_q   <= 1'b0;
         io_port_q <= 8'h00;
         io_data_q <= 8'h00;
      end else begin
         state_q   <= state_d;
         kind_q    <= kind_d;
         wr_q      <= wr_d;
         addr_q    <= addr_d;
         cnt_q     <= cnt_d;
         di_q      <= di_d;
         io_wr_q   <= io_we;
         io_port_q <= io_port_d;
         io_data_q <= io_data_d;
      end
   end

   // In IDLE the read port follows the live bus so a zero-wait read has its
   // byte registered on the start edge; afterwards it tracks the latch.
   assign raddr = (state_q == ST_IDLE) ? i_a[P_ADDR_W-1:0] : addr_q[P_ADDR_W-1:0];

   tb_ram_sp #(.P_ADDR_W(P_ADDR_W)) u_ram (
      .i_clk     (i_clk),
      .i_we      (mem_we),
      .i_waddr   (addr_q[P_ADDR_W-1:0]),
      .i_wdata   (i_dout),
      .i_raddr   (raddr),
      .o_rdata   (ram_rdata),
      .i_ld_we   (i_ld_we),
      .i_ld_addr (i_ld_addr),
      .i_ld_data (i_ld_data)
   );

`ifdef MEMRESP_WRLOG_EN
   logic [15:0] wr_count_q, wr_last_q;

   always_ff @(posedge i_clk or posedge i_reset_btn) begin
      if (i_reset_btn) begin
         wr_count_q <= '0;
         wr_last_q  <= '0;
      end else if (mem_we) begin
         wr_count_q <= wr_count_q + 16'd1;
         wr_last_q  <= addr_q;
      end
   end

   assign o_wr_count     = wr_count_q;
   assign o_wr_last_addr = wr_last_q;
`else
   assign o_wr_count     = '0;
   assign o_wr_last_addr = '0;
`endif

   assign o_wait_n  = (state_q != ST_WAIT);
   assign o_di      = di_q;
   assign o_io_wr   = io_wr_q;
   assign o_io_port = io_port_q;
   assign o_io_data = io_data_q;

endmodule

// File: tb/tb_tv80_mem_responder.sv
// tb_tv80_mem_responder
//   Directed bench for tv80_mem_responder with M1 wait 0, memory wait 3,
//   IO wait 1. Expected values are hand-computed constants.
module tb_tv80_mem_responder;
   import tv80_bus_pkg::*;

`ifdef MEMRESP_WRLOG_EN
   localparam bit WRLOG = 1'b1;
`else
   localparam bit WRLOG = 1'b0;
`endif

   logic        i_clk = 1'b0;
   logic        i_reset_btn;
   logic [15:0] i_a;
   logic [7:0]  i_dout;
   logic [7:0]  o_di;
   logic        i_mreq_n, i_iorq_n, i_rd_n, i_wr_n, i_m1_n, i_rfsh_n;
   logic        o_wait_n;
   logic        i_ld_we;
   logic [15:0] i_ld_addr;
   logic [7:0]  i_ld_data;
   logic        o_io_wr;
   logic [7:0]  o_io_port, o_io_data;
   logic [15:0] o_wr_count, o_wr_last_addr;

   int total = 0;
   int bad   = 0;

   always #5 i_clk = ~i_clk;

   tv80_mem_responder #(
      .P_ADDR_W(16), .P_M1_WAIT(0), .P_MEM_WAIT(3), .P_IO_WAIT(1),
      .P_IO_DEFAULT(8'hFF)
   ) dut (
      .i_clk(i_clk), .i_reset_btn(i_reset_btn), .i_a(i_a), .i_dout(i_dout),
      .o_di(o_di), .i_mreq_n(i_mreq_n), .i_iorq_n(i_iorq_n), .i_rd_n(i_rd_n),
      .i_wr_n(i_wr_n), .i_m1_n(i_m1_n), .i_rfsh_n(i_rfsh_n), .o_wait_n(o_wait_n),
      .i_ld_we(i_ld_we), .i_ld_addr(i_ld_addr), .i_ld_data(i_ld_data),
      .o_io_wr(o_io_wr), .o_io_port(o_io_port), .o_io_data(o_io_data),
      .o_wr_count(o_wr_count), .o_wr_last_addr(o_wr_last_addr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge i_clk);
      #1;
   endtask

   task automatic idle_bus;
      i_mreq_n = 1'b1; i_iorq_n = 1'b1; i_rd_n = 1'b1;
      i_wr_n   = 1'b1; i_m1_n   = 1'b1; i_rfsh_n = 1'b1;
   endtask

   task automatic backdoor(input logic [15:0] ad, input logic [7:0] d);
      i_ld_we = 1'b1; i_ld_addr = ad; i_ld_data = d;
      step;
      i_ld_we = 1'b0;
   endtask

   // Runs one complete bus cycle expecting n wait states. Returns o_di at
   // the data-valid point, the number of samples with o_wait_n low and the
   // number of samples with o_io_wr high. With collide set, a backdoor
   // write of cd to the same address is issued on the commit edge.
   task automatic cycle(input bit io, input bit m1, input bit wr,
                        input logic [15:0] ad, input logic [7:0] wd, input int n,
                        input bit collide, input logic [7:0] cd,
                        output logic [7:0] rd, output int lows, output int pulses);
      i_a = ad; i_dout = wd;
      if (io) i_iorq_n = 1'b0; else i_mreq_n = 1'b0;
      if (m1) i_m1_n = 1'b0;
      if (wr) i_wr_n = 1'b0; else i_rd_n = 1'b0;
      lows = 0; pulses = 0;
      for (int i = 0; i < n + 2; i++) begin
         if (collide && i == n + 1) begin
            i_ld_we = 1'b1; i_ld_addr = ad; i_ld_data = cd;
         end
         step;
         i_ld_we = 1'b0;
         if (!o_wait_n) lows++;
         if (o_io_wr)   pulses++;
      end
      rd = o_di;
      idle_bus;
      step;
      if (!o_wait_n) lows++;
      if (o_io_wr)   pulses++;
   endtask

   initial begin
      logic [7:0] rd;
      int lows, pulses;

      i_reset_btn = 1'b1;
      idle_bus;
      i_a = '0; i_dout = '0;
      i_ld_we = 1'b0; i_ld_addr = '0; i_ld_data = '0;
      #12;
      chk("rst_di",      32'(o_di),           32'h00);
      chk("rst_wait_n",  32'(o_wait_n),       32'h1);
      chk("rst_io_wr",   32'(o_io_wr),        32'h0);
      chk("rst_io_port", 32'(o_io_port),      32'h00);
      chk("rst_io_data", 32'(o_io_data),      32'h00);
      chk("rst_wr_cnt",  32'(o_wr_count),     32'h0);
      chk("rst_wr_last", 32'(o_wr_last_addr), 32'h0);
      i_reset_btn = 1'b0;
      step;

      backdoor(16'h0000, 8'h00);
      backdoor(16'h0001, 8'hC3);
      backdoor(16'h1234, 8'hA5);

      // M1 fetches, zero waits
      cycle(1'b0, 1'b1, 1'b0, 16'h0000, 8'h00, 0, 1'b0, 8'h00, rd, lows, pulses);
      chk("m1_0_data",  32'(rd), 32'h00);
      chk("m1_0_waits", lows,    0);
      cycle(1'b0, 1'b1, 1'b0, 16'h0001, 8'h00, 0, 1'b0, 8'h00, rd, lows, pulses);
      chk("m1_1_data",  32'(rd), 32'hC3);
      chk("m1_1_waits", lows,    0);

      // Memory read, 3 waits
      cycle(1'b0, 1'b0, 1'b0, 16'h1234, 8'h00, 3, 1'b0, 8'h00, rd, lows, pulses);
      chk("mrd_data",  32'(rd), 32'hA5);
      chk("mrd_waits", lows,    3);

      // Memory write then read back
      cycle(1'b0, 1'b0, 1'b1, 16'h8000, 8'h5A, 3, 1'b0, 8'h00, rd, lows, pulses);
      chk("mwr_waits",   lows, 3);
      chk("mwr_cnt",     32'(o_wr_count),     WRLOG ? 32'd1 : 32'd0);
      chk("mwr_last",    32'(o_wr_last_addr), WRLOG ? 32'h8000 : 32'h0);
      cycle(1'b0, 1'b0, 1'b0, 16'h8000, 8'h00, 3, 1'b0, 8'h00, rd, lows, pulses);
      chk("mwr_readback", 32'(rd), 32'h5A);

      // IO write and IO read
      cycle(1'b1, 1'b0, 1'b1, 16'hAB10, 8'h42, 1, 1'b0, 8'h00, rd, lows, pulses);
      chk("iowr_pulses", pulses, 1);
      chk("iowr_waits",  lows,   1);
      chk("iowr_port",   32'(o_io_port), 32'h10);
      chk("iowr_data",   32'(o_io_data), 32'h42);
      cycle(1'b1, 1'b0, 1'b0, 16'h0020, 8'h00, 1, 1'b0, 8'h00, rd, lows, pulses);
      chk("iord_data",   32'(rd), 32'hFF);
      chk("iord_pulses", pulses,  0);

      // Refresh with a stray write strobe must not start or write
      i_a = 16'h1234; i_dout = 8'h77;
      i_mreq_n = 1'b0; i_rfsh_n = 1'b0; i_wr_n = 1'b0;
      lows = 0;
      for (int i = 0; i < 4; i++) begin
         step;
         if (!o_wait_n) lows++;
      end
      chk("rfsh_waits", lows, 0);
      idle_bus;
      step;
      cycle(1'b0, 1'b0, 1'b0, 16'h1234, 8'h00, 3, 1'b0, 8'h00, rd, lows, pulses);
      chk("rfsh_ram", 32'(rd), 32'hA5);

      // Interrupt acknowledge is ignored
      i_iorq_n = 1'b0; i_m1_n = 1'b0; i_rd_n = 1'b0;
      lows = 0;
      for (int i = 0; i < 4; i++) begin
         step;
         if (!o_wait_n) lows++;
      end
      chk("intack_waits", lows, 0);
      chk("intack_di",    32'(o_di), 32'hA5);
      idle_bus;
      step;

      // Abort of a read and of a write during WAIT
      i_a = 16'h8000; i_mreq_n = 1'b0; i_rd_n = 1'b0;
      step; step;
      chk("abort_rd_wait", 32'(o_wait_n), 32'h0);
      idle_bus;
      step; step;
      chk("abort_rd_wait_n", 32'(o_wait_n), 32'h1);
      chk("abort_rd_di",     32'(o_di),     32'hA5);
      i_a = 16'h1234; i_dout = 8'h11; i_mreq_n = 1'b0; i_wr_n = 1'b0;
      step; step;
      idle_bus;
      step; step;
      cycle(1'b0, 1'b0, 1'b0, 16'h1234, 8'h00, 3, 1'b0, 8'h00, rd, lows, pulses);
      chk("abort_wr_ram", 32'(rd), 32'hA5);

      // CPU write beats a same-address backdoor write
      cycle(1'b0, 1'b0, 1'b1, 16'h2000, 8'h33, 3, 1'b1, 8'h44, rd, lows, pulses);
      cycle(1'b0, 1'b0, 1'b0, 16'h2000, 8'h00, 3, 1'b0, 8'h00, rd, lows, pulses);
      chk("collide_cpu_wins", 32'(rd), 32'h33);
      chk("collide_cnt",  32'(o_wr_count),     WRLOG ? 32'd2 : 32'd0);
      chk("collide_last", 32'(o_wr_last_addr), WRLOG ? 32'h2000 : 32'h0);
      backdoor(16'h2001, 8'h66);
      cycle(1'b0, 1'b0, 1'b0, 16'h2001, 8'h00, 3, 1'b0, 8'h00, rd, lows, pulses);
      chk("backdoor_rd", 32'(rd), 32'h66);

      // Reset during WAIT of a write drops it
      i_a = 16'h8000; i_dout = 8'h99; i_mreq_n = 1'b0; i_wr_n = 1'b0;
      step; step;
      chk("rstmid_wait", 32'(o_wait_n), 32'h0);
      i_reset_btn = 1'b1;
      #1;
      chk("rstmid_wait_n",  32'(o_wait_n),   32'h1);
      chk("rstmid_io_port", 32'(o_io_port),  32'h00);
      chk("rstmid_cnt",     32'(o_wr_count), 32'h0);
      idle_bus;
      step;
      i_reset_btn = 1'b0;
      step;
      cycle(1'b0, 1'b0, 1'b0, 16'h8000, 8'h00, 3, 1'b0, 8'h00, rd, lows, pulses);
      chk("rstmid_ram", 32'(rd), 32'h5A);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
